// File: rtl/sale_terminal_fsm.sv
// sale_terminal_fsm: top-level control FSM of the sale terminal.
// Sequences barcode, grid, quantity, basket edit and checkout.
//
// Ports:
//   CLOCK_50, RESET      clock, sync active-high reset
//   key_pulse, sel_pulse one-cycle key / select strobes
//   sw_interactive/edit  debounced mode switches
//   barcode_*            barcode status in, push/clear out
//   nav_id, nav_*        navigator product in, step/clear out
//   basket_full          basket cannot take a new line
//   state                current state code
//   product_id, quantity latched product and quantity
//   basket_add/cancel    basket strobes
//   error, checkout      error level, checkout strobe
// Build option: SALE_TERMINAL_TIMEOUT_EN enables the
// inactivity timeout in the waiting states.
module sale_terminal_fsm #(
  parameter int NUM_KEYS        = 4,
  parameter int DIGIT_W         = 4,
  parameter int ID_W            = 4,
  parameter int QTY_W           = 4,
  parameter int QTY_MAX         = 9,
  parameter int ERR_HOLD_CYCLES = 100_000_000,
  parameter int TIMEOUT_CYCLES  = 500_000_000,
  parameter int CNT_W           = 32
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] key_pulse,
  input  logic                sel_pulse,
  input  logic                sw_interactive,
  input  logic                sw_edit,
  input  logic                barcode_complete,
  input  logic                barcode_valid,
  input  logic [ID_W-1:0]     barcode_id,
  input  logic [ID_W-1:0]     nav_id,
  input  logic                basket_full,
  output logic [2:0]          state,
  output logic [DIGIT_W-1:0]  barcode_digit,
  output logic                barcode_push,
  output logic                barcode_clear,
  output logic [1:0]          nav_dir,
  output logic                nav_step,
  output logic                nav_clear,
  output logic [ID_W-1:0]     product_id,
  output logic [QTY_W-1:0]    quantity,
  output logic                basket_add,
  output logic                basket_cancel,
  output logic                error,
  output logic                checkout
);

  typedef enum logic [2:0] {
    S_START    = 3'd0,
    S_IDLE     = 3'd1,
    S_BARCODE  = 3'd2,
    S_INTER    = 3'd3,
    S_QTY      = 3'd4,
    S_EDIT     = 3'd5,
    S_CHECKOUT = 3'd6,
    S_ERROR    = 3'd7
  } state_t;

  localparam int KI_W = $clog2(NUM_KEYS);
  localparam logic [CNT_W-1:0] ERR_LAST =
    CNT_W'(ERR_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [NUM_KEYS-1:0] KEY_ONE = NUM_KEYS'(1);

`ifdef SALE_TERMINAL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  // Counter then serves the ERROR dwell only.
  localparam bit TO_EN = 1'b0;
`endif

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_run;
  logic [KI_W-1:0]  key_idx;
  logic             key_evt;
  logic             active;
  logic             wait_st;
  logic             timed_out;
  int               qty_sum;
  logic [QTY_W-1:0] qty_add;
  logic [DIGIT_W-1:0] key_digit;

  assign state = st;

  always_comb begin
    key_idx = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (key_pulse[k]) key_idx = KI_W'(k);
  end

  // One-hot key with no concurrent select.
  assign key_evt = (key_pulse != '0) &&
    ((key_pulse & (key_pulse - KEY_ONE)) == '0) &&
    !sel_pulse;
  assign active = (key_pulse != '0) || sel_pulse;

  assign key_digit =
    DIGIT_W'(NUM_KEYS - int'(key_idx));

  always_comb begin
    qty_sum = int'(quantity) + int'(key_idx) + 1;
    if (qty_sum > QTY_MAX) qty_add = QTY_W'(QTY_MAX);
    else qty_add = QTY_W'(qty_sum);
  end

  assign wait_st = (st == S_BARCODE) ||
    (st == S_INTER) || (st == S_QTY) ||
    (st == S_EDIT);
  assign timed_out = TO_EN && wait_st &&
    !active && (cnt == TO_LAST);
  // Quiet-time counter; any press restarts it.
  assign cnt_run = (TO_EN && !active) ?
    cnt + CNT_ONE : '0;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      st            <= S_START;
      cnt           <= '0;
      barcode_digit <= '0;
      barcode_push  <= 1'b0;
      barcode_clear <= 1'b0;
      nav_dir       <= 2'b00;
      nav_step      <= 1'b0;
      nav_clear     <= 1'b0;
      product_id    <= '0;
      quantity      <= '0;
      basket_add    <= 1'b0;
      basket_cancel <= 1'b0;
      error         <= 1'b0;
      checkout      <= 1'b0;
    end else begin
      barcode_push  <= 1'b0;
      barcode_clear <= 1'b0;
      nav_step      <= 1'b0;
      nav_clear     <= 1'b0;
      basket_add    <= 1'b0;
      basket_cancel <= 1'b0;
      error         <= 1'b0;
      checkout      <= 1'b0;
      if (timed_out) begin
        barcode_clear <= 1'b1;
        nav_clear     <= 1'b1;
        quantity      <= '0;
        cnt           <= '0;
        st            <= S_IDLE;
      end else begin
        unique case (st)
          S_START: begin
            barcode_clear <= 1'b1;
            nav_clear     <= 1'b1;
            cnt           <= '0;
            st            <= S_IDLE;
          end
          S_IDLE: begin
            cnt <= '0;
            if (sel_pulse) begin
              checkout <= 1'b1;
              st       <= S_CHECKOUT;
            end else if (sw_edit) begin
              barcode_clear <= 1'b1;
              nav_clear     <= 1'b1;
              st            <= S_EDIT;
            end else if (sw_interactive) begin
              barcode_clear <= 1'b1;
              nav_clear     <= 1'b1;
              st            <= S_INTER;
            end else begin
              st <= S_BARCODE;
            end
          end
          S_BARCODE: begin
            cnt <= cnt_run;
            if (sw_interactive || sw_edit) begin
              barcode_clear <= 1'b1;
              st            <= S_IDLE;
            end else if (!barcode_complete) begin
              if (key_evt) begin
                barcode_push  <= 1'b1;
                barcode_digit <= key_digit;
              end
            end else if (!barcode_valid) begin
              barcode_clear <= 1'b1;
              error         <= 1'b1;
              cnt           <= '0;
              st            <= S_ERROR;
            end else if (sel_pulse) begin
              product_id    <= barcode_id;
              barcode_clear <= 1'b1;
              quantity      <= '0;
              cnt           <= '0;
              st            <= S_QTY;
            end
          end
          S_INTER: begin
            cnt <= cnt_run;
            if (sw_edit) begin
              nav_clear <= 1'b1;
              cnt       <= '0;
              st        <= S_EDIT;
            end else if (!sw_interactive) begin
              nav_clear <= 1'b1;
              st        <= S_IDLE;
            end else if (sel_pulse) begin
              product_id <= nav_id;
              nav_clear  <= 1'b1;
              quantity   <= '0;
              cnt        <= '0;
              st         <= S_QTY;
            end else if (key_evt) begin
              unique case (1'b1)
                key_pulse[0]: begin
                  nav_dir  <= 2'b11;
                  nav_step <= 1'b1;
                end
                key_pulse[1]: begin
                  nav_dir  <= 2'b10;
                  nav_step <= 1'b1;
                end
                key_pulse[2]: begin
                  nav_dir  <= 2'b01;
                  nav_step <= 1'b1;
                end
                key_pulse[3]: begin
                  nav_dir  <= 2'b00;
                  nav_step <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          S_QTY: begin
            cnt <= cnt_run;
            if (sel_pulse) begin
              if (quantity != '0) begin
                if (basket_full) begin
                  error <= 1'b1;
                  cnt   <= '0;
                  st    <= S_ERROR;
                end else begin
                  basket_add <= 1'b1;
                  st         <= S_IDLE;
                end
              end
            end else if (key_evt) begin
              quantity <= qty_add;
            end
          end
          S_EDIT: begin
            cnt <= cnt_run;
            if (!sw_edit) begin
              nav_clear <= 1'b1;
              st        <= S_IDLE;
            end else if (sel_pulse) begin
              product_id    <= nav_id;
              basket_cancel <= 1'b1;
            end else if (key_evt && key_pulse[1]) begin
              nav_dir  <= 2'b10;
              nav_step <= 1'b1;
            end else if (key_evt && key_pulse[2]) begin
              nav_dir  <= 2'b01;
              nav_step <= 1'b1;
            end
          end
          S_CHECKOUT: begin
            cnt <= '0;
            st  <= S_START;
          end
          S_ERROR: begin
            if (cnt == ERR_LAST) begin
              cnt <= '0;
              st  <= S_IDLE;
            end else begin
              cnt   <= cnt + CNT_ONE;
              error <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sale_terminal_fsm.sv
// tb_sale_terminal_fsm: directed vectors, corner sequences
// and a randomized run against a behavioural model.
module tb_sale_terminal_fsm;

  localparam int HOLD = 16;
  localparam int TOUT = 32;
  localparam int QMAX = 9;
`ifdef SALE_TERMINAL_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  localparam logic [7:0] NONE = 8'h00;
  localparam logic [7:0] PUSH = 8'h80;
  localparam logic [7:0] BCL  = 8'h40;
  localparam logic [7:0] STEP = 8'h20;
  localparam logic [7:0] NCL  = 8'h10;
  localparam logic [7:0] ADD  = 8'h08;
  localparam logic [7:0] CAN  = 8'h04;
  localparam logic [7:0] ERR  = 8'h02;
  localparam logic [7:0] CO   = 8'h01;

  logic       CLOCK_50 = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] key_pulse = '0;
  logic       sel_pulse = 1'b0;
  logic       sw_interactive = 1'b0;
  logic       sw_edit = 1'b0;
  logic       barcode_complete = 1'b0;
  logic       barcode_valid = 1'b0;
  logic [3:0] barcode_id = '0;
  logic [3:0] nav_id = '0;
  logic       basket_full = 1'b0;
  logic [2:0] state;
  logic [3:0] barcode_digit;
  logic       barcode_push;
  logic       barcode_clear;
  logic [1:0] nav_dir;
  logic       nav_step;
  logic       nav_clear;
  logic [3:0] product_id;
  logic [3:0] quantity;
  logic       basket_add;
  logic       basket_cancel;
  logic       error;
  logic       checkout;

  int checks = 0;
  int errors = 0;

  sale_terminal_fsm #(
    .NUM_KEYS(4), .DIGIT_W(4), .ID_W(4), .QTY_W(4),
    .QTY_MAX(QMAX), .ERR_HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TOUT), .CNT_W(32)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET),
    .key_pulse(key_pulse), .sel_pulse(sel_pulse),
    .sw_interactive(sw_interactive),
    .sw_edit(sw_edit),
    .barcode_complete(barcode_complete),
    .barcode_valid(barcode_valid),
    .barcode_id(barcode_id), .nav_id(nav_id),
    .basket_full(basket_full), .state(state),
    .barcode_digit(barcode_digit),
    .barcode_push(barcode_push),
    .barcode_clear(barcode_clear),
    .nav_dir(nav_dir), .nav_step(nav_step),
    .nav_clear(nav_clear), .product_id(product_id),
    .quantity(quantity), .basket_add(basket_add),
    .basket_cancel(basket_cancel), .error(error),
    .checkout(checkout)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: modes use the documented codes,
  // quantities and timers are plain integers.
  int m_mode = 0, m_quiet = 0, m_dwell = 0;
  int m_q = 0, m_pid = 0, m_digit = 0, m_dir = 0;
  bit m_push, m_bc, m_step, m_nc, m_add, m_can;
  bit m_err, m_co;

  always @(posedge CLOCK_50) begin : model
    int kidx, nxt, ones;
    bit kev, act;
    {m_push, m_bc, m_step, m_nc} = '0;
    {m_add, m_can, m_co} = '0;
    ones = $countones(key_pulse);
    kidx = 0;
    for (int k = 0; k < 4; k++)
      if (key_pulse[k]) kidx = k;
    kev = (ones == 1) && !sel_pulse;
    act = (ones != 0) || sel_pulse;
    if (RESET) begin
      m_mode = 0; m_quiet = 0; m_dwell = 0;
      m_q = 0; m_pid = 0; m_digit = 0; m_dir = 0;
    end else if (m_mode == 0) begin
      m_bc = 1; m_nc = 1; m_mode = 1;
    end else if (m_mode == 1) begin
      m_quiet = 0;
      if (sel_pulse) begin m_co = 1; m_mode = 6; end
      else if (sw_edit) begin
        m_bc = 1; m_nc = 1; m_mode = 5;
      end else if (sw_interactive) begin
        m_bc = 1; m_nc = 1; m_mode = 3;
      end else m_mode = 2;
    end else if (m_mode == 6) begin
      m_mode = 0;
    end else if (m_mode == 7) begin
      if (m_dwell == HOLD - 1) m_mode = 1;
      else m_dwell++;
    end else if (TO_ON && !act &&
                 m_quiet == TOUT - 1) begin
      m_bc = 1; m_nc = 1; m_q = 0; m_mode = 1;
    end else begin
      nxt = m_mode;
      m_quiet = (act || !TO_ON) ? 0 : m_quiet + 1;
      case (m_mode)
        2: if (sw_interactive || sw_edit) begin
             m_bc = 1; nxt = 1;
           end else if (!barcode_complete) begin
             if (kev) begin
               m_push = 1; m_digit = 4 - kidx;
             end
           end else if (!barcode_valid) begin
             m_bc = 1; nxt = 7;
           end else if (sel_pulse) begin
             m_pid = barcode_id; m_bc = 1; nxt = 4;
           end
        3: if (sw_edit) begin m_nc = 1; nxt = 5; end
           else if (!sw_interactive) begin
             m_nc = 1; nxt = 1;
           end else if (sel_pulse) begin
             m_pid = nav_id; m_nc = 1; nxt = 4;
           end else if (kev) begin
             m_step = 1; m_dir = 3 - kidx;
           end
        4: if (sel_pulse) begin
             if (m_q != 0) begin
               if (basket_full) nxt = 7;
               else begin m_add = 1; nxt = 1; end
             end
           end else if (kev) begin
             m_q = m_q + kidx + 1;
             if (m_q > QMAX) m_q = QMAX;
           end
        default:
           if (!sw_edit) begin m_nc = 1; nxt = 1; end
           else if (sel_pulse) begin
             m_pid = nav_id; m_can = 1;
           end else if (kev && kidx == 1) begin
             m_step = 1; m_dir = 2;
           end else if (kev && kidx == 2) begin
             m_step = 1; m_dir = 1;
           end
      endcase
      if (nxt != m_mode) begin
        m_quiet = 0;
        if (nxt == 7) m_dwell = 0;
        if (nxt == 4) m_q = 0;
      end
      m_mode = nxt;
    end
    m_err = (m_mode == 7);
  end

  function automatic logic [24:0] dut_pack();
    return {state, barcode_digit, barcode_push,
      barcode_clear, nav_dir, nav_step, nav_clear,
      product_id, quantity, basket_add,
      basket_cancel, error, checkout};
  endfunction

  function automatic logic [24:0] model_pack();
    return {3'(m_mode), 4'(m_digit), m_push, m_bc,
      2'(m_dir), m_step, m_nc, 4'(m_pid), 4'(m_q),
      m_add, m_can, m_err, m_co};
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic step(input logic [3:0] k,
                      input logic s);
    key_pulse = k;
    sel_pulse = s;
    tick();
    key_pulse = '0;
    sel_pulse = 1'b0;
  endtask

  task automatic expect_out(input string nm,
    input logic [2:0] st, input logic [7:0] stb,
    input logic [3:0] dig, input logic [1:0] dir,
    input logic [3:0] pid, input logic [3:0] qty);
    logic [24:0] g, e;
    g = dut_pack();
    e = {st, dig, stb[7], stb[6], dir, stb[5],
         stb[4], pid, qty, stb[3:0]};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, g, e);
    end
  endtask

  // Fifteen ignored cycles after ERROR entry, then IDLE.
  task automatic dwell(input string nm,
    input logic [3:0] dig, input logic [1:0] dir,
    input logic [3:0] pid, input logic [3:0] qty);
    for (int i = 1; i < HOLD; i++) begin
      step(4'b0001 << $urandom_range(0, 3),
           1'($urandom_range(0, 1)));
      expect_out(nm, 3'd7, ERR, dig, dir, pid, qty);
    end
    step('0, 1'b0);
    expect_out({nm, "_exit"}, 3'd1, NONE,
               dig, dir, pid, qty);
  endtask

  typedef struct {
    logic [3:0] key;
    logic       sel, cmp, vld, full;
    logic [3:0] bid;
    logic [2:0] st;
    logic [7:0] stb;
    logic [3:0] dig, pid, qty;
  } vec_t;

  function automatic vec_t mk(
    input logic [3:0] key, input logic sel,
    input logic cmp, input logic vld,
    input logic [3:0] bid, input logic full,
    input logic [2:0] st, input logic [7:0] stb,
    input logic [3:0] dig, input logic [3:0] pid,
    input logic [3:0] qty);
    vec_t v;
    v.key = key; v.sel = sel; v.cmp = cmp;
    v.vld = vld; v.bid = bid; v.full = full;
    v.st = st; v.stb = stb; v.dig = dig;
    v.pid = pid; v.qty = qty;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    bit busy;
    int r;
    tick();
    tick();
    expect_out("reset", 3'd0, NONE, 0, 0, 0, 0);
    RESET = 1'b0;

    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, BCL|NCL, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, NONE, 0, 0, 0));
    tbl.push_back(mk(8, 0, 0, 0, 0, 0, 2, PUSH, 1, 0, 0));
    tbl.push_back(mk(4, 0, 0, 0, 0, 0, 2, PUSH, 2, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 2, PUSH, 3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2, PUSH, 4, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 5, 0, 4, BCL, 4, 5, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 4, NONE, 4, 5, 2));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 4, NONE, 4, 5, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4, NONE, 4, 5, 5));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, ADD, 4, 5, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, NONE, 4, 5, 5));
    tbl.push_back(mk(0, 1, 1, 1, 9, 0, 4, BCL, 4, 9, 0));
    tbl.push_back(mk(8, 0, 0, 0, 0, 0, 4, NONE, 4, 9, 4));
    tbl.push_back(mk(8, 0, 0, 0, 0, 0, 4, NONE, 4, 9, 8));
    tbl.push_back(mk(8, 0, 0, 0, 0, 0, 4, NONE, 4, 9, 9));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 7, ERR, 4, 9, 9));

    foreach (tbl[i]) begin
      barcode_complete = tbl[i].cmp;
      barcode_valid    = tbl[i].vld;
      barcode_id       = tbl[i].bid;
      basket_full      = tbl[i].full;
      step(tbl[i].key, tbl[i].sel);
      expect_out($sformatf("vec%0d", i), tbl[i].st,
        tbl[i].stb, tbl[i].dig, 0, tbl[i].pid,
        tbl[i].qty);
    end
    {barcode_complete, barcode_valid} = '0;
    basket_full = 1'b0;
    barcode_id = '0;
    dwell("full_err", 4, 0, 9, 9);

    // Invalid barcode.
    step('0, 1'b0);
    expect_out("inv_bar", 3'd2, NONE, 4, 0, 9, 9);
    barcode_complete = 1'b1;
    barcode_valid = 1'b0;
    step('0, 1'b0);
    expect_out("inv_err", 3'd7, BCL|ERR, 4, 0, 9, 9);
    dwell("inv_dwell", 4, 0, 9, 9);
    barcode_complete = 1'b0;

    // Interactive, select/key collision, multi-hot.
    sw_interactive = 1'b1;
    step('0, 1'b0);
    expect_out("int_in", 3'd3, BCL|NCL, 4, 0, 9, 9);
    step(4'b0001, 1'b0);
    expect_out("int_k0", 3'd3, STEP, 4, 3, 9, 9);
    nav_id = 4'd7;
    step('0, 1'b1);
    expect_out("int_sel", 3'd4, NCL, 4, 3, 7, 0);
    step('0, 1'b1);
    expect_out("qty0_sel", 3'd4, NONE, 4, 3, 7, 0);
    step(4'b0001, 1'b0);
    expect_out("qty_k0", 3'd4, NONE, 4, 3, 7, 1);
    step('0, 1'b1);
    expect_out("qty_add", 3'd1, ADD, 4, 3, 7, 1);
    step('0, 1'b0);
    expect_out("int_in2", 3'd3, BCL|NCL, 4, 3, 7, 1);
    nav_id = 4'd3;
    step(4'b0010, 1'b1);
    expect_out("sel_wins", 3'd4, NCL, 4, 3, 3, 0);
    step(4'b0011, 1'b0);
    expect_out("multihot", 3'd4, NONE, 4, 3, 3, 0);
    step(4'b0001, 1'b0);
    expect_out("qty_k0b", 3'd4, NONE, 4, 3, 3, 1);
    sw_interactive = 1'b0;
    RESET = 1'b1;
    step('0, 1'b0);
    expect_out("mid_rst", 3'd0, NONE, 0, 0, 0, 0);
    RESET = 1'b0;

    // Edit mode and checkout.
    sw_edit = 1'b1;
    step('0, 1'b0);
    expect_out("rst_start", 3'd1, BCL|NCL, 0, 0, 0, 0);
    step('0, 1'b0);
    expect_out("edit_in", 3'd5, BCL|NCL, 0, 0, 0, 0);
    step(4'b0001, 1'b0);
    expect_out("edit_k0", 3'd5, NONE, 0, 0, 0, 0);
    step(4'b0100, 1'b0);
    expect_out("edit_up", 3'd5, STEP, 0, 1, 0, 0);
    step(4'b0010, 1'b0);
    expect_out("edit_dn", 3'd5, STEP, 0, 2, 0, 0);
    nav_id = 4'd6;
    step('0, 1'b1);
    expect_out("edit_can", 3'd5, CAN, 0, 2, 6, 0);
    sw_edit = 1'b0;
    step('0, 1'b0);
    expect_out("edit_out", 3'd1, NCL, 0, 2, 6, 0);
    step('0, 1'b1);
    expect_out("checkout", 3'd6, CO, 0, 2, 6, 0);
    step('0, 1'b0);
    expect_out("co_start", 3'd0, NONE, 0, 2, 6, 0);
    step('0, 1'b0);
    expect_out("co_idle", 3'd1, BCL|NCL, 0, 2, 6, 0);

    // Inactivity timeout in QUANTITY.
    step('0, 1'b0);
    barcode_complete = 1'b1;
    barcode_valid = 1'b1;
    barcode_id = 4'd2;
    step('0, 1'b1);
    expect_out("to_qty", 3'd4, BCL, 0, 2, 2, 0);
    barcode_complete = 1'b0;
    step(4'b0001, 1'b0);
    expect_out("to_k0", 3'd4, NONE, 0, 2, 2, 1);
    for (int i = 1; i < TOUT; i++) begin
      step('0, 1'b0);
      expect_out("to_wait", 3'd4, NONE, 0, 2, 2, 1);
    end
    step('0, 1'b0);
`ifdef SALE_TERMINAL_TIMEOUT_EN
    expect_out("timeout", 3'd1, BCL|NCL, 0, 2, 2, 0);
`else
    expect_out("no_tout", 3'd4, NONE, 0, 2, 2, 1);
`endif

    // Randomized run against the model.
    RESET = 1'b1;
    step('0, 1'b0);
    RESET = 1'b0;
    busy = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) busy = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      key_pulse = '0;
      if (r < (busy ? 30 : 2))
        key_pulse = 4'b0001 << $urandom_range(0, 3);
      else if (r < (busy ? 35 : 3))
        key_pulse = 4'($urandom);
      sel_pulse = ($urandom_range(0, 99) <
                   (busy ? 12 : 1));
      if ($urandom_range(0, 99) < 3)
        sw_interactive = ~sw_interactive;
      if ($urandom_range(0, 99) < 3)
        sw_edit = ~sw_edit;
      barcode_complete = ($urandom_range(0, 99) <
                          (busy ? 10 : 1));
      barcode_valid = ($urandom_range(0, 99) < 70);
      barcode_id = 4'($urandom);
      nav_id = 4'($urandom);
      basket_full = ($urandom_range(0, 99) < 30);
      RESET = ($urandom_range(0, 999) < 3);
      tick();
      checks++;
      if (dut_pack() !== model_pack()) begin
        errors++;
        $display("FAIL rand cyc %0d: got %h expected %h",
                 c, dut_pack(), model_pack());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sale_terminal_fsm.md
# sale_terminal_fsm

Parametrised top-level control state machine for the sale terminal. It sequences barcode entry, interactive grid selection, multi-press quantity entry, basket editing and checkout. It drives the barcode shift register, the direction-to-product navigator and the basket controller with registered single-cycle strobes, with no external level-to-pulse converters. Over the previous controller it adds a dedicated error state with hold time, an inactivity timeout, accumulated and saturating quantity entry, and a basket-full check.

## Interface
Parameters:
- NUM_KEYS, 4, number of digit/direction keys; must be ≥ 4
- DIGIT_W, 4, barcode digit width
- ID_W, 4, product ID width
- QTY_W, 4, quantity width
- QTY_MAX, 9, quantity saturation value; must fit in QTY_W
- ERR_HOLD_CYCLES, 100_000_000, ERROR state dwell (2 s at 50 MHz)
- TIMEOUT_CYCLES, 500_000_000, inactivity limit (10 s at 50 MHz)
- CNT_W, 32, width of the shared dwell/timeout counter

Ports:
- CLOCK_50  in  1  sole clock
- RESET  in  1  synchronous, active-high reset
- key_pulse  in  NUM_KEYS  one-cycle press strobes; bit k = KEY[k]
- sel_pulse  in  1  one-cycle select strobe
- sw_interactive  in  1  debounced SW1 level
- sw_edit  in  1  debounced SW2 level
- barcode_complete  in  1  all BARCODE digits captured
- barcode_valid  in  1  decoder reports a known product
- barcode_id  in  ID_W  decoded product ID
- nav_id  in  ID_W  product under the navigator cursor
- basket_full  in  1  basket cannot take a new line
- state  out  3  current state code
- barcode_digit  out  DIGIT_W  digit to shift in
- barcode_push  out  1  shift-in strobe
- barcode_clear  out  1  clear strobe
- nav_dir  out  2  00 left, 01 up, 10 down, 11 right
- nav_step  out  1  cursor move strobe
- nav_clear  out  1  cursor reset strobe
- product_id  out  ID_W  latched product
- quantity  out  QTY_W  accumulated quantity
- basket_add  out  1  add strobe
- basket_cancel  out  1  remove strobe
- error  out  1  high while in ERROR
- checkout  out  1  end-of-shopping strobe

## Operation
- State codes: 0 START, 1 IDLE, 2 BARCODE, 3 INTERACTIVE, 4 QUANTITY, 5 EDIT, 6 CHECKOUT, 7 ERROR.
- A key event is `key_pulse` with exactly one bit set. Zero or multi-hot patterns are ignored.
- If `sel_pulse` and a key event arrive in the same cycle, select wins and the key is dropped.
- START: pulse `barcode_clear` and `nav_clear`, then go to IDLE.
- IDLE: priority is `sel_pulse` → CHECKOUT, then `sw_edit` → EDIT, then `sw_interactive` → INTERACTIVE, else → BARCODE. The EDIT and INTERACTIVE entries pulse `barcode_clear` and `nav_clear`.
- BARCODE:
  - If either switch is high: pulse `barcode_clear` and go to IDLE.
  - While `!barcode_complete`: a key event on bit k pulses `barcode_push` with `barcode_digit` = NUM_KEYS−k.
  - When complete and invalid: pulse `barcode_clear` and go to ERROR.
  - When complete, valid and `sel_pulse`: latch `product_id` = `barcode_id`, pulse `barcode_clear`, go to QUANTITY.
- INTERACTIVE:
  - If `sw_edit`: pulse `nav_clear` and go to EDIT.
  - Else if `!sw_interactive`: pulse `nav_clear` and go to IDLE.
  - Else `sel_pulse`: latch `product_id` = `nav_id`, pulse `nav_clear`, go to QUANTITY.
  - Else a key event pulses `nav_step`; bit 0/1/2/3 selects `nav_dir` 11/10/01/00.
- QUANTITY:
  - `quantity` is cleared to 0 on entry.
  - Key bit k adds k+1, saturating at QTY_MAX.
  - `sel_pulse` with `quantity` = 0 is ignored.
  - Otherwise, if `basket_full`, go to ERROR; else pulse `basket_add` and go to IDLE.
  - `product_id` and `quantity` hold until the next latch.
- EDIT:
  - If `!sw_edit`: pulse `nav_clear` and go to IDLE.
  - `sel_pulse`: latch `product_id` = `nav_id`, pulse `basket_cancel`, stay in EDIT.
  - Key bit 1 steps down (`nav_dir` 10); key bit 2 steps up (01); all other keys are ignored.
- CHECKOUT: pulse `checkout`, then go to START.
- ERROR:
  - `error` = 1 for ERR_HOLD_CYCLES cycles, then go to IDLE.
  - All inputs, including the switches, are ignored.
- Timeout (applies in BARCODE, INTERACTIVE, QUANTITY and EDIT):
  - The counter restarts on state entry, on any `key_pulse` bit and on `sel_pulse`.
  - Reaching TIMEOUT_CYCLES−1 pulses `barcode_clear` and `nav_clear`, zeroes `quantity`, and goes to IDLE.

## Timing
- All outputs are registered.
- Each strobe is exactly one cycle, asserted in the cycle after the triggering input pulse, coincident with any state change.
- Reset values: `state` = 0 (START), all strobes 0, `error` 0, `barcode_digit` 0, `nav_dir` 0, `product_id` 0, `quantity` 0, counter 0.
- First cycle after reset release: START, which emits the clear strobes.
- RESET asserted in any state overrides everything on the next edge: pending strobes are dropped and a partial quantity is lost.
- ERROR dwell: `error` is high for exactly ERR_HOLD_CYCLES cycles; `state` = IDLE follows on the next cycle.
- Transitions from IDLE take one cycle. IDLE is never occupied for more than one cycle without a switch or select.

## Configuration
- SALE_TERMINAL_TIMEOUT_EN defined: the inactivity timeout is implemented as described in Operation.
- Undefined:
  - The counter serves ERROR dwell only.
  - BARCODE, INTERACTIVE, QUANTITY and EDIT wait indefinitely.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Barcode flow: keys KEY3,KEY2,KEY1,KEY0 → `barcode_push` digits 1,2,3,4. Then `barcode_complete`=1, `barcode_valid`=1, `barcode_id`=5, `sel_pulse` → `product_id`=5, `state`=4. Then KEY1 ×2 and KEY0 → `quantity`=5; `sel_pulse` → one-cycle `basket_add`, `state`=1 then 2.
- Saturation and full: QTY_MAX=9, KEY3 ×3 → `quantity`=9. `sel_pulse` with `basket_full`=1 → `state`=7, `error` high exactly ERR_HOLD_CYCLES (bench value 16), then `state`=1, no `basket_add`.
- Invalid barcode: complete with `barcode_valid`=0 → `barcode_clear` strobe, ERROR entered, keys and `sel_pulse` during dwell produce no strobes.
- Interactive and edit: `sw_interactive`=1, KEY0 → `nav_step` with `nav_dir`=11; `sel_pulse` with `nav_id`=7 → `product_id`=7, `state`=4. Then `sw_edit`=1 from IDLE, KEY0 → no step; KEY2 → `nav_dir`=01; `sel_pulse` → `basket_cancel`.
- Simultaneity and reset: `sel_pulse` and KEY1 in the same cycle in INTERACTIVE → only the select effect. Multi-hot `key_pulse`=0011 → ignored. RESET mid-QUANTITY → next cycle `quantity`=0, `state`=0, then the clear strobes.
- Timeout (macro defined, TIMEOUT_CYCLES=32): enter QUANTITY, press KEY0, idle 32 cycles → `quantity`=0, clear strobes, `state`=1. Macro undefined → state remains 4.
